// File: rtl/alu_req_arbiter.sv
// Round-robin front end that lets NUM_REQ control units share one combinational ALU.
// Each accepted op is registered onto the ALU, its result is captured a cycle later, and it is returned tagged with the requester id.
module alu_req_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 3,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*8-1:0] req_a,
  input  logic [NUM_REQ*8-1:0] req_b,
  input  logic [NUM_REQ*4-1:0] req_sel,
  output logic [7:0]           alu_a,
  output logic [7:0]           alu_b,
  output logic [3:0]           alu_sel,
  input  logic [7:0]           alu_out,
  input  logic                 alu_carry,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [7:0]           rsp_data,
  output logic                 rsp_carry,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [ID_W-1:0] LAST_GRANT_INIT = ID_W'(NUM_REQ - 1);

  state_t             state;
  state_t             state_nxt;
  logic [ID_W-1:0]    last_grant;
  logic [ID_W-1:0]    grant_idx;
  logic [NUM_REQ-1:0] grant_onehot;
  logic               grant_found;

  // Search starts just after the previous winner, so every requester gets a turn.
  always_comb begin
    int idx;
    idx          = 0;
    grant_onehot = '0;
    grant_idx    = '0;
    grant_found  = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(last_grant) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found       = 1'b1;
        grant_idx         = idx[ID_W-1:0];
        grant_onehot[idx] = 1'b1;
      end
    end
  end

  assign req_ready = (state == IDLE && !reset) ? grant_onehot : '0;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_found) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // alu_* only change on a grant, so they stay put while a response is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= LAST_GRANT_INIT;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      rsp_id     <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_carry  <= 1'b0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            alu_a      <= req_a[int'(grant_idx)*8 +: 8];
            alu_b      <= req_b[int'(grant_idx)*8 +: 8];
            alu_sel    <= req_sel[int'(grant_idx)*4 +: 4];
            rsp_id     <= grant_idx;
            last_grant <= grant_idx;
          end
        end
        EXEC: begin
          rsp_data  <= alu_out;
          rsp_carry <= alu_carry;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter: a behavioural ALU sits on the alu_* side and a scoreboard queue holds expected responses.
// A second instance with a 4-bit counter shares all stimulus so counter wrap can be reached quickly.
module tb_alu_req_arbiter;
  localparam int NUM_REQ = 2;
  localparam int ID_W    = 3;
  localparam int CNT_W   = 16;
  localparam int CNT_W_S = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*8-1:0] req_a;
  logic [NUM_REQ*8-1:0] req_b;
  logic [NUM_REQ*4-1:0] req_sel;
  logic [7:0]           alu_a, alu_b, alu_out;
  logic [3:0]           alu_sel;
  logic                 alu_carry;
  logic                 rsp_valid, rsp_ready, rsp_carry, busy;
  logic [7:0]           rsp_data;
  logic [ID_W-1:0]      rsp_id;
  logic [CNT_W-1:0]     op_count;

  logic [NUM_REQ-1:0]   req_ready_s;
  logic [7:0]           alu_a_s, alu_b_s, rsp_data_s;
  logic [3:0]           alu_sel_s;
  logic                 rsp_valid_s, rsp_carry_s, busy_s;
  logic [ID_W-1:0]      rsp_id_s;
  logic [CNT_W_S-1:0]   op_count_s;

  typedef struct packed {
    logic [7:0]      data;
    logic            carry;
    logic [ID_W-1:0] id;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  alu_req_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_id(rsp_id),
    .busy(busy), .op_count(op_count)
  );

  alu_req_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W_S)) dut_small (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready_s),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .alu_a(alu_a_s), .alu_b(alu_b_s), .alu_sel(alu_sel_s),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid_s), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data_s), .rsp_carry(rsp_carry_s), .rsp_id(rsp_id_s),
    .busy(busy_s), .op_count(op_count_s)
  );

  // Stand-in for the shared ALU: carry is the 9th bit of add, borrow for subtract.
  function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] sel);
    logic [8:0] r;
    case (sel)
      4'h0:    r = {1'b0, a} + {1'b0, b};
      4'h1:    r = {1'b0, a} - {1'b0, b};
      4'h2:    r = {1'b0, a & b};
      4'h3:    r = {1'b0, a | b};
      4'h4:    r = {1'b0, a ^ b};
      default: r = {1'b0, ~a};
    endcase
    return r;
  endfunction

  assign {alu_carry, alu_out} = alu_model(alu_a, alu_b, alu_sel);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input int r, input logic [7:0] a, input logic [7:0] b,
                                input logic [3:0] sel);
    req_a[r*8 +: 8]   = a;
    req_b[r*8 +: 8]   = b;
    req_sel[r*4 +: 4] = sel;
    req_valid[r]      = 1'b1;
  endtask

  task automatic wait_grant(output int g);
    g = -1;
    for (int k = 0; k < 20; k++) begin
      if (req_ready != '0) begin
        for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) g = i;
        break;
      end
      @(negedge clk);
    end
    if (g < 0) check("grant_timeout", 32'd0, 32'd1);
  endtask

  // Drives one op from requester r, waits for its grant and lets the accepting edge pass.
  task automatic issue(input int r, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] sel, input logic [7:0] ed, input logic ec,
                       input bit push);
    int g;
    @(negedge clk);
    apply_stimulus(r, a, b, sel);
    #1;
    wait_grant(g);
    check("grant_id", g, r);
    if (push) exp_q.push_back('{data: ed, carry: ec, id: ID_W'(r)});
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic check_output(output int lat);
    rsp_t e;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      if (rsp_valid) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    if (lat < 0) begin
      check("rsp_timeout", 32'd0, 32'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      check("unexpected_rsp", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("rsp_data", rsp_data, e.data);
      check("rsp_carry", rsp_carry, e.carry);
      check("rsp_id", rsp_id, e.id);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int               lat;
    int               g;
    int               seen;
    logic [CNT_W-1:0] cnt_next;
    logic [7:0]       a, b;
    logic [3:0]       sel;
    logic [8:0]       m;
    rsp_t             held;

    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sel   = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);

    // T1: reset values, then a single add with exact latency
    check("t1_rst_req_ready", req_ready, 0);
    check("t1_rst_alu_a", alu_a, 0);
    check("t1_rst_alu_b", alu_b, 0);
    check("t1_rst_alu_sel", alu_sel, 0);
    check("t1_rst_rsp_valid", rsp_valid, 0);
    check("t1_rst_rsp_data", rsp_data, 0);
    check("t1_rst_rsp_carry", rsp_carry, 0);
    check("t1_rst_rsp_id", rsp_id, 0);
    check("t1_rst_busy", busy, 0);
    check("t1_rst_op_count", op_count, 0);
    @(negedge clk);
    reset     = 1'b0;
    rsp_ready = 1'b1;
    issue(0, 8'h0A, 8'h02, 4'h0, 8'h0C, 1'b0, 1'b1);
    check("t1_busy_exec", busy, 1);
    check("t1_alu_a", alu_a, 8'h0A);
    check("t1_alu_b", alu_b, 8'h02);
    check_output(lat);
    check("t1_latency", lat, 2);
    check("t1_op_count", op_count, 1);
    check("t1_rsp_valid_low", rsp_valid, 0);
    check("t1_busy_idle", busy, 0);

    // T2: add with carry out, then one op from requester 1
    issue(0, 8'hF6, 8'h0A, 4'h0, 8'h00, 1'b1, 1'b1);
    check_output(lat);
    issue(1, 8'hF0, 8'h3C, 4'h2, 8'h30, 1'b0, 1'b1);
    check_output(lat);
    check("t2_op_count", op_count, 3);

    // T3: both requesters continuously valid must alternate 0,1,0,1,...
    @(negedge clk);
    apply_stimulus(0, 8'h11, 8'h22, 4'h0);
    apply_stimulus(1, 8'h80, 8'h01, 4'h1);
    #1;
    for (int i = 0; i < 6; i++) begin
      wait_grant(g);
      check("t3_grant", g, i % 2);
      if (i % 2 == 0) exp_q.push_back('{data: 8'h33, carry: 1'b0, id: ID_W'(0)});
      else            exp_q.push_back('{data: 8'h7F, carry: 1'b0, id: ID_W'(1)});
      @(posedge clk);
      #1;
      if (i == 5) req_valid = '0;
      check_output(lat);
    end
    check("t3_op_count", op_count, 9);

    // T4: stalled response holds everything and blocks arbitration
    @(negedge clk);
    rsp_ready = 1'b0;
    issue(0, 8'h33, 8'h44, 4'h4, 8'h77, 1'b0, 1'b1);
    for (int k = 0; k < 10 && !rsp_valid; k++) @(negedge clk);
    apply_stimulus(1, 8'h55, 8'h0F, 4'h3);
    cnt_next = op_count + CNT_W'(1);
    held = (exp_q.size() > 0) ? exp_q[0] : '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t4_rsp_valid", rsp_valid, 1);
      check("t4_rsp_data", rsp_data, held.data);
      check("t4_rsp_carry", rsp_carry, held.carry);
      check("t4_rsp_id", rsp_id, held.id);
      check("t4_req_ready", req_ready, 0);
      check("t4_busy", busy, 1);
      check("t4_alu_a", alu_a, 8'h33);
      check("t4_op_count_hold", op_count, cnt_next - CNT_W'(1));
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    check_output(lat);
    check("t4_release_lat", lat, 0);
    check("t4_op_count", op_count, cnt_next);
    repeat (3) @(negedge clk);
    check("t4_single_handshake", op_count, cnt_next);
    check("t4_rsp_valid_low", rsp_valid, 0);

    // T5: reset during EXEC drops the op
    issue(0, 8'h01, 8'h01, 4'h0, 8'h02, 1'b0, 1'b0);
    check("t5_in_exec", busy, 1);
    reset = 1'b1;
    #1;
    check("t5_busy", busy, 0);
    check("t5_rsp_valid", rsp_valid, 0);
    check("t5_alu_a", alu_a, 0);
    check("t5_alu_sel", alu_sel, 0);
    check("t5_rsp_data", rsp_data, 0);
    check("t5_rsp_id", rsp_id, 0);
    check("t5_op_count", op_count, 0);
    @(negedge clk);
    reset = 1'b0;
    seen  = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    check("t5_no_rsp", seen, 0);
    check("t5_op_count_after", op_count, 0);

    // T6: counter wrap, seen on the 4-bit instance after 16 ops
    a = 8'h00; b = 8'h00; sel = 4'h0; m = '0;
    for (int i = 0; i < 16; i++) begin
      a   = 8'($urandom);
      b   = 8'($urandom);
      sel = 4'($urandom_range(0, 15));
      m   = alu_model(a, b, sel);
      issue(i % 2, a, b, sel, m[7:0], m[8], 1'b1);
      check_output(lat);
      if (i == 14) begin
        check("t6_small_max", op_count_s, 4'hF);
        check("t6_count_15", op_count, 15);
      end
    end
    check("t6_small_wrap", op_count_s, 4'h0);
    check("t6_count_16", op_count, 16);
    check("t6_small_rsp_data", rsp_data_s, m[7:0]);
    check("t6_small_rsp_carry", rsp_carry_s, m[8]);
    check("t6_small_rsp_id", rsp_id_s, 1);
    check("t6_small_alu_a", alu_a_s, a);
    check("t6_small_alu_b", alu_b_s, b);
    check("t6_small_alu_sel", alu_sel_s, sel);
    check("t6_small_idle", {busy_s, rsp_valid_s, req_ready_s}, 0);
    check("t6_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
